// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes the serial line, recovers frames by mid-bit
// sampling and presents bytes on a valid/ready handshake with error pulses.
module uart_rx #(
    parameter logic [13:0] COUNT_NUM = 14'd10415
) (
    input  logic       clk_i,
    input  logic       srst_i,
    input  logic       RxD_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } state_t;

    localparam logic [13:0] HALF_COUNT = COUNT_NUM >> 1;

    logic        rx_meta_r;
    logic        rxs_r;
    state_t      state_r;
    state_t      state_nxt_s;
    logic [13:0] cnt_r;
    logic [13:0] cnt_nxt_s;
    logic [2:0]  idx_r;
    logic [2:0]  idx_nxt_s;
    logic [7:0]  sr_r;
    logic [7:0]  sr_nxt_s;
    logic        deliver_s;
    logic        ferr_s;

    // Two-flop synchronizer for the asynchronous serial line, idling high.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            rx_meta_r <= 1'b1;
            rxs_r     <= 1'b1;
        end else begin
            rx_meta_r <= RxD_i;
            rxs_r     <= rx_meta_r;
        end
    end

    // Frame FSM state, baud counter, bit index and shift register.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_r <= ST_IDLE;
            cnt_r   <= 14'd0;
            idx_r   <= 3'd0;
            sr_r    <= 8'h00;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            idx_r   <= idx_nxt_s;
            sr_r    <= sr_nxt_s;
        end
    end

    // Next-state logic; START checks the start bit at its centre, later bits one period apart.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        idx_nxt_s   = idx_r;
        sr_nxt_s    = sr_r;
        deliver_s   = 1'b0;
        ferr_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = 14'd0;
                if (!rxs_r) begin
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r == HALF_COUNT) begin
                    cnt_nxt_s = 14'd0;
                    idx_nxt_s = 3'd0;
                    if (rxs_r) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + 14'd1;
                end
            end
            ST_DATA: begin
                if (cnt_r == COUNT_NUM) begin
                    cnt_nxt_s = 14'd0;
                    sr_nxt_s  = {rxs_r, sr_r[7:1]};
                    if (idx_r == 3'd7) begin
                        state_nxt_s = ST_STOP;
                    end else begin
                        idx_nxt_s = idx_r + 3'd1;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + 14'd1;
                end
            end
            ST_STOP: begin
                if (cnt_r == COUNT_NUM) begin
                    cnt_nxt_s = 14'd0;
                    if (rxs_r) begin
                        deliver_s   = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        ferr_s      = 1'b1;
                        state_nxt_s = ST_WAIT_HIGH;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + 14'd1;
                end
            end
            ST_WAIT_HIGH: begin
                // A held-low (break) line must not look like a fresh start bit.
                if (rxs_r) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_HIGH;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 14'd0;
            end
        endcase
    end

    // Output handshake: load on delivery unless an unconsumed byte would be lost.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            data_o      <= 8'h00;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            frame_err_o <= ferr_s;
            overrun_o   <= deliver_s && valid_o && !ready_i;
            if (deliver_s && !(valid_o && !ready_i)) begin
                data_o  <= sr_r;
                valid_o <= 1'b1;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end else begin
                valid_o <= valid_o;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at COUNT_NUM=15: directed scenarios plus
// randomized frames checked against delivery times computed from the frame rules.
module tb_uart_rx;

    localparam int P       = 16;
    localparam int H       = 7;
    localparam int LATENCY = H + 4 + 9 * P;

    logic       clk_i = 1'b0;
    logic       srst_i = 1'b1;
    logic       RxD_i = 1'b1;
    logic       ready_i = 1'b1;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       overrun_o;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    int         acc_cyc[$];
    logic [7:0] acc_dat[$];
    int         fe_cyc[$];
    int         ov_cyc[$];
    logic [7:0] ov_dat[$];

    uart_rx #(.COUNT_NUM(14'd15)) dut (
        .clk_i       (clk_i),
        .srst_i      (srst_i),
        .RxD_i       (RxD_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Event recorder sampled on the falling edge.
    always @(negedge clk_i) begin
        if (valid_o && ready_i) begin
            acc_cyc.push_back(cyc);
            acc_dat.push_back(data_o);
        end
        if (frame_err_o) fe_cyc.push_back(cyc);
        if (overrun_o) begin
            ov_cyc.push_back(cyc);
            ov_dat.push_back(data_o);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic idle(input int n);
        RxD_i = 1'b1;
        tick(n);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, output int t_fall);
        logic [9:0] frame;
        frame  = {stop_v, b, 1'b0};
        t_fall = cyc;
        for (int i = 0; i < 10; i++) begin
            RxD_i = frame[i];
            tick(P);
        end
    endtask

    // One good byte since the given queue marks, accepted at fall + LATENCY.
    task automatic check_rx(input string tag, input int a0, input int f0, input int o0,
                            input logic [7:0] b, input int t_fall);
        int na;
        na = acc_cyc.size() - a0;
        check({tag, "_count"}, na, 1);
        check({tag, "_cycle"}, (na >= 1) ? acc_cyc[a0] : -1, t_fall + LATENCY);
        check({tag, "_data"}, (na >= 1) ? {24'd0, acc_dat[a0]} : 32'hffff_ffff, {24'd0, b});
        check({tag, "_ferr"}, fe_cyc.size() - f0, 0);
        check({tag, "_ovr"}, ov_cyc.size() - o0, 0);
    endtask

    initial begin
        int t1, t2, a0, f0, o0;
        logic [7:0] b;
        logic [7:0] exp_b[$];
        int         exp_t[$];

        tick(3);
        srst_i = 1'b0;
        check("rst_data", {24'd0, data_o}, 32'h0);
        check("rst_valid", valid_o, 1'b0);
        check("rst_ferr", frame_err_o, 1'b0);
        check("rst_ovr", overrun_o, 1'b0);
        idle(5);

        // Single frame latency and data.
        a0 = acc_cyc.size(); f0 = fe_cyc.size(); o0 = ov_cyc.size();
        send_frame(8'hA5, 1'b1, t1);
        idle(5);
        check_rx("a5", a0, f0, o0, 8'hA5, t1);

        // Back-to-back frames with no idle bit.
        a0 = acc_cyc.size(); f0 = fe_cyc.size(); o0 = ov_cyc.size();
        send_frame(8'h00, 1'b1, t1);
        send_frame(8'hFF, 1'b1, t2);
        idle(10);
        check("b2b_count", acc_cyc.size() - a0, 2);
        if (acc_cyc.size() - a0 >= 2) begin
            check("b2b_c0", acc_cyc[a0], t1 + LATENCY);
            check("b2b_c1", acc_cyc[a0 + 1], t2 + LATENCY);
            check("b2b_gap", acc_cyc[a0 + 1] - acc_cyc[a0], 160);
            check("b2b_d0", {24'd0, acc_dat[a0]}, 32'h00);
            check("b2b_d1", {24'd0, acc_dat[a0 + 1]}, 32'hFF);
        end
        check("b2b_ferr", fe_cyc.size() - f0, 0);

        // Short glitch is a false start.
        a0 = acc_cyc.size(); f0 = fe_cyc.size(); o0 = ov_cyc.size();
        RxD_i = 1'b0;
        tick(4);
        idle(60);
        check("glitch_valid", acc_cyc.size() - a0, 0);
        check("glitch_ferr", fe_cyc.size() - f0, 0);
        check("glitch_ovr", ov_cyc.size() - o0, 0);
        send_frame(8'h3C, 1'b1, t1);
        idle(5);
        check_rx("3c", a0, f0, o0, 8'h3C, t1);

        // Framing error with the line held low afterwards.
        a0 = acc_cyc.size(); f0 = fe_cyc.size(); o0 = ov_cyc.size();
        send_frame(8'h55, 1'b0, t1);
        tick(40);
        idle(40);
        check("ferr_count", fe_cyc.size() - f0, 1);
        check("ferr_cycle", (fe_cyc.size() - f0 >= 1) ? fe_cyc[f0] : -1, t1 + LATENCY);
        check("ferr_valid", acc_cyc.size() - a0, 0);
        check("ferr_ovr", ov_cyc.size() - o0, 0);
        check("ferr_valid_lvl", valid_o, 1'b0);
        a0 = acc_cyc.size(); f0 = fe_cyc.size(); o0 = ov_cyc.size();
        send_frame(8'h81, 1'b1, t1);
        idle(5);
        check_rx("81", a0, f0, o0, 8'h81, t1);

        // Overrun: consumer stalled across two frames.
        a0 = acc_cyc.size(); f0 = fe_cyc.size(); o0 = ov_cyc.size();
        ready_i = 1'b0;
        send_frame(8'h11, 1'b1, t1);
        idle(10);
        check("ovr_valid1", valid_o, 1'b1);
        check("ovr_data1", {24'd0, data_o}, 32'h11);
        send_frame(8'h22, 1'b1, t2);
        idle(10);
        check("ovr_count", ov_cyc.size() - o0, 1);
        check("ovr_cycle", (ov_cyc.size() - o0 >= 1) ? ov_cyc[o0] : -1, t2 + LATENCY);
        check("ovr_data_at", (ov_cyc.size() - o0 >= 1) ? {24'd0, ov_dat[o0]} : 32'hffff_ffff, 32'h11);
        check("ovr_valid2", valid_o, 1'b1);
        check("ovr_data2", {24'd0, data_o}, 32'h11);
        check("ovr_noacc", acc_cyc.size() - a0, 0);
        ready_i = 1'b1;
        @(negedge clk_i);
        check("ovr_hold", valid_o, 1'b1);
        @(posedge clk_i);
        #1;
        check("ovr_clear", valid_o, 1'b0);
        check("ovr_acc", acc_cyc.size() - a0, 1);
        check("ovr_acc_d", (acc_cyc.size() - a0 >= 1) ? {24'd0, acc_dat[a0]} : 32'hffff_ffff, 32'h11);
        check("ovr_ferr", fe_cyc.size() - f0, 0);
        idle(5);

        // Reset mid-frame with an unconsumed byte waiting.
        ready_i = 1'b0;
        send_frame(8'h5A, 1'b1, t1);
        idle(10);
        check("srst_pre_valid", valid_o, 1'b1);
        check("srst_pre_data", {24'd0, data_o}, 32'h5A);
        b = 8'hF5;
        RxD_i = 1'b0;
        tick(P);
        for (int k = 0; k < 4; k++) begin
            RxD_i = b[k];
            tick(P);
        end
        RxD_i = b[4];
        tick(8);
        srst_i = 1'b1;
        tick(1);
        srst_i = 1'b0;
        check("srst_valid", valid_o, 1'b0);
        check("srst_data", {24'd0, data_o}, 32'h0);
        check("srst_ferr", frame_err_o, 1'b0);
        check("srst_ovr", overrun_o, 1'b0);
        ready_i = 1'b1;
        a0 = acc_cyc.size(); f0 = fe_cyc.size(); o0 = ov_cyc.size();
        tick(P - 9);
        for (int k = 5; k < 8; k++) begin
            RxD_i = b[k];
            tick(P);
        end
        idle(P + 40);
        check("srst_tail_valid", acc_cyc.size() - a0, 0);
        check("srst_tail_ferr", fe_cyc.size() - f0, 0);
        check("srst_tail_ovr", ov_cyc.size() - o0, 0);
        send_frame(8'hC3, 1'b1, t1);
        idle(5);
        check_rx("c3", a0, f0, o0, 8'hC3, t1);

        // Random bytes with random idle gaps, checked against the timing model.
        a0 = acc_cyc.size(); f0 = fe_cyc.size(); o0 = ov_cyc.size();
        for (int n = 0; n < 10; n++) begin
            idle($urandom_range(0, 20));
            b = 8'($urandom);
            send_frame(b, 1'b1, t1);
            exp_b.push_back(b);
            exp_t.push_back(t1 + LATENCY);
        end
        idle(10);
        check("rnd_count", acc_cyc.size() - a0, exp_b.size());
        for (int n = 0; n < exp_b.size(); n++) begin
            if (a0 + n < acc_cyc.size()) begin
                check("rnd_cycle", acc_cyc[a0 + n], exp_t[n]);
                check("rnd_data", {24'd0, acc_dat[a0 + n]}, {24'd0, exp_b[n]});
            end
        end
        check("rnd_ferr", fe_cyc.size() - f0, 0);
        check("rnd_ovr", ov_cyc.size() - o0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
